// File: rtl/bus_arbiter_2to1.sv
// Two-requester round-robin arbiter for the shared memory port (0 = fetch, 1 = load/store).
// Optional busy watchdog enabled by defining HAZE_ARB_TIMEOUT_EN.
module bus_arbiter_2to1 #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_N,
  input  logic                  i_REQ0,
  input  logic [ADDR_WIDTH-1:0] i_ADDR0,
  input  logic                  i_REQ1,
  input  logic [ADDR_WIDTH-1:0] i_ADDR1,
  input  logic                  i_WE1,
  input  logic                  i_MEM_DONE,
  output logic                  o_GNT0,
  output logic                  o_GNT1,
  output logic                  o_SEL,
  output logic                  o_MEM_VALID,
  output logic [ADDR_WIDTH-1:0] o_ADDR,
  output logic                  o_WE,
  output logic                  o_DONE0,
  output logic                  o_DONE1,
  output logic                  o_ERR
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_t;

  state_t state_r;
  state_t state_next_s;
  logic   last_r;
  logic   sel_r;
  logic   busy_s;
  logic   timeout_s;
  logic   complete_s;
  logic   start0_s;
  logic   start1_s;

  assign busy_s     = (state_r == ST_BUSY0) || (state_r == ST_BUSY1);
  assign complete_s = i_MEM_DONE | timeout_s;
  assign start0_s   = (state_next_s == ST_BUSY0) && (state_r != ST_BUSY0);
  assign start1_s   = (state_next_s == ST_BUSY1) && (state_r != ST_BUSY1);

`ifdef HAZE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_r;

  // Busy-cycle watchdog: restarts on every new grant, idles at zero.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      cnt_r <= '0;
    end else if (start0_s || start1_s) begin
      cnt_r <= '0;
    end else if (busy_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= '0;
    end
  end

  // A real completion in the same cycle takes precedence over the watchdog.
  assign timeout_s = busy_s && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) && !i_MEM_DONE;
`else
  // TIMEOUT_CYCLES only matters with the watchdog; grants otherwise wait for i_MEM_DONE.
  assign timeout_s = 1'b0 & (TIMEOUT_CYCLES >= 2);
`endif

  // Next-state decision: round-robin in IDLE, back-to-back handoff on completion.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_REQ0 && (!i_REQ1 || last_r)) begin
          state_next_s = ST_BUSY0;
        end else if (i_REQ1) begin
          state_next_s = ST_BUSY1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY0: begin
        if (complete_s) begin
          state_next_s = i_REQ1 ? ST_BUSY1 : ST_IDLE;
        end else begin
          state_next_s = ST_BUSY0;
        end
      end
      ST_BUSY1: begin
        if (complete_s) begin
          state_next_s = i_REQ0 ? ST_BUSY0 : ST_IDLE;
        end else begin
          state_next_s = ST_BUSY1;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, last-served pointer and mux select; select holds through IDLE.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_r <= ST_IDLE;
      last_r  <= 1'b1;
      sel_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (start0_s) begin
        last_r <= 1'b0;
        sel_r  <= 1'b0;
      end else if (start1_s) begin
        last_r <= 1'b1;
        sel_r  <= 1'b1;
      end else begin
        last_r <= last_r;
        sel_r  <= sel_r;
      end
    end
  end

  // Decodes are forced low while reset is asserted, even before the reset edge.
  assign o_GNT0      = i_RST_N & (state_r == ST_BUSY0);
  assign o_GNT1      = i_RST_N & (state_r == ST_BUSY1);
  assign o_MEM_VALID = o_GNT0 | o_GNT1;
  assign o_SEL       = sel_r;
  assign o_ADDR      = sel_r ? i_ADDR1 : i_ADDR0;
  assign o_WE        = i_WE1 & o_GNT1;
  assign o_DONE0     = o_GNT0 & i_MEM_DONE;
  assign o_DONE1     = o_GNT1 & i_MEM_DONE;
  assign o_ERR       = i_RST_N & timeout_s;

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Self-checking bench for bus_arbiter_2to1: directed scenarios then random traffic,
// compared against an owner/round-robin reference model (honours HAZE_ARB_TIMEOUT_EN).
module tb_bus_arbiter_2to1;

  localparam int AW = 32;
  localparam int TO = 4;
`ifdef HAZE_ARB_TIMEOUT_EN
  localparam bit HAS_TO = 1'b1;
`else
  localparam bit HAS_TO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic          we1 = 1'b0;
  logic          mem_done = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;
  logic          gnt0, gnt1, sel, mem_valid, we, done0, done1, err;
  logic [AW-1:0] addr;

  int checks = 0;
  int failures = 0;

  // reference model: current owner (-1 none), last served port, select, busy cycle number
  int m_owner = -1;
  int m_last  = 1;
  int m_sel   = 0;
  int m_cycle = 0;

  bus_arbiter_2to1 #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .i_CLK(clk), .i_RST_N(rst_n),
    .i_REQ0(req0), .i_ADDR0(addr0),
    .i_REQ1(req1), .i_ADDR1(addr1), .i_WE1(we1),
    .i_MEM_DONE(mem_done),
    .o_GNT0(gnt0), .o_GNT1(gnt1), .o_SEL(sel), .o_MEM_VALID(mem_valid),
    .o_ADDR(addr), .o_WE(we), .o_DONE0(done0), .o_DONE1(done1), .o_ERR(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input logic r, input logic q0, input logic q1, input logic w,
                      input logic md, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bit act, e_g0, e_g1, e_to, fin;
    int other;
    @(negedge clk);
    rst_n = r; req0 = q0; req1 = q1; we1 = w; mem_done = md; addr0 = a0; addr1 = a1;
    #1;
    act  = r;
    e_g0 = act && (m_owner == 0);
    e_g1 = act && (m_owner == 1);
    e_to = HAS_TO && act && (m_owner >= 0) && (m_cycle == TO) && !md;
    check_eq("gnt0", 64'(gnt0), 64'(e_g0));
    check_eq("gnt1", 64'(gnt1), 64'(e_g1));
    check_eq("mem_valid", 64'(mem_valid), 64'(e_g0 | e_g1));
    check_eq("sel", 64'(sel), 64'(m_sel));
    check_eq("addr", 64'(addr), 64'((m_sel == 1) ? a1 : a0));
    check_eq("we", 64'(we), 64'(w & e_g1));
    check_eq("done0", 64'(done0), 64'(e_g0 & md));
    check_eq("done1", 64'(done1), 64'(e_g1 & md));
    check_eq("err", 64'(err), 64'(e_to));
    check_eq("gnt_exclusive", 64'(gnt0 & gnt1), 64'(0));
    if (!r) begin
      m_owner = -1; m_last = 1; m_sel = 0; m_cycle = 0;
    end else if (m_owner < 0) begin
      if (q0 && q1) m_owner = (m_last == 0) ? 1 : 0;
      else if (q0) m_owner = 0;
      else if (q1) m_owner = 1;
      if (m_owner >= 0) begin
        m_last = m_owner; m_sel = m_owner; m_cycle = 1;
      end
    end else begin
      fin = md || e_to;
      if (fin) begin
        other = 1 - m_owner;
        if ((other == 0) ? q0 : q1) begin
          m_owner = other; m_last = other; m_sel = other; m_cycle = 1;
        end else begin
          m_owner = -1; m_cycle = 0;
        end
      end else begin
        m_cycle++;
      end
    end
  endtask

  initial begin
    // 1: reset held with everything asserted, then release
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    // 2: single fetch at 0x100, completion on the third busy cycle
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0);
    // 3: both requesting, completion every 3rd cycle
    for (int i = 0; i < 15; i++)
      step(1'b1, 1'b1, 1'b1, 1'(i % 2), 1'((i % 3) == 2), 32'h200, 32'h300);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    // 4: fetch held across its own completion re-arbitrates via IDLE
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'(i == 2), 32'h400, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    // 5: load/store with no completion for 22 cycles
    for (int i = 0; i < 22; i++)
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h500);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    // 6: reset during BUSY1, then a tie
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h600);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h600);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h600);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h700, 32'h600);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h700, 32'h600);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h700, 32'h600);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h700, 32'h600);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step(1'(($urandom % 64) != 0), 1'($urandom % 2), 1'($urandom % 2),
           1'($urandom % 2), 1'(($urandom % 3) == 0), AW'($urandom), AW'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
